// File: rtl/sipo_deserializer_if.sv
// Serial-in / word-out bundle between the serial source, the deserializer and the word consumer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             busy;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output ser_in, ser_valid, frame_start, par_ready, clr_ovf,
    input  par_data, par_valid, busy, overflow
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, par_ready, clr_ovf,
    output par_data, par_valid, busy, overflow
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Reassembles WIDTH-bit words from a strobed serial stream into a one-entry
// valid/ready holding register, with a sticky flag for words lost to backpressure.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  sipo_deserializer_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] asm;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] seed;
  logic             complete;
  logic             load;
  logic             drop;

  always_comb begin
    word = '0;
    seed = '0;
    if (MSB_FIRST != 0) begin
      word = {asm[WIDTH-2:0], bus.ser_in};
      seed = {{(WIDTH-1){1'b0}}, bus.ser_in};
    end else begin
      word = {bus.ser_in, asm[WIDTH-1:1]};
      seed = {bus.ser_in, {(WIDTH-1){1'b0}}};
    end
  end

  // frame_start discards the partial word, so it also suppresses completion.
  assign complete = bus.ser_valid && !bus.frame_start && (cnt == LAST);
  assign load     = complete && (!bus.par_valid || bus.par_ready);
  assign drop     = complete && bus.par_valid && !bus.par_ready;

  // Assembly stage: shift register and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm <= '0;
      cnt <= '0;
    end else if (bus.frame_start) begin
      asm <= bus.ser_valid ? seed : '0;
      cnt <= bus.ser_valid ? CW'(1) : '0;
    end else if (bus.ser_valid) begin
      asm <= word;
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Holding stage: one-entry output register and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.par_data  <= '0;
      bus.par_valid <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      if (load) begin
        bus.par_data  <= word;
        bus.par_valid <= 1'b1;
      end else if (bus.par_valid && bus.par_ready) begin
        bus.par_valid <= 1'b0;
      end
      if (drop) begin
        bus.overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        bus.overflow <= 1'b0;
      end
    end
  end

  assign bus.busy = (cnt != '0);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: expected words queued at stimulus time, popped on each
// accepted transfer of the MSB-first instance; an LSB-first instance shares the stream.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(4)) bus1 ();
  sipo_deserializer_if #(.WIDTH(4)) bus2 ();

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobed bit into both instances; returns 1 time unit after the sampling edge.
  task automatic bit_in(input logic b);
    bus1.ser_in = b; bus1.ser_valid = 1'b1;
    bus2.ser_in = b; bus2.ser_valid = 1'b1;
    @(posedge clk); #1;
    bus1.ser_valid = 1'b0;
    bus2.ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) bit_in(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus1.par_valid && bus1.par_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_pop_avail", sb_q.size(), 1);
      end else begin
        check_eq("sb_word", bus1.par_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus1.ser_in = 0; bus1.ser_valid = 0; bus1.frame_start = 0; bus1.par_ready = 0; bus1.clr_ovf = 0;
    bus2.ser_in = 0; bus2.ser_valid = 0; bus2.frame_start = 0; bus2.par_ready = 1; bus2.clr_ovf = 0;
    idle(2);
    check_eq("rst_valid", bus1.par_valid, 0);
    check_eq("rst_data", bus1.par_data, 0);
    check_eq("rst_ovf", bus1.overflow, 0);
    check_eq("rst_busy", bus1.busy, 0);
    rst = 1'b0;
    idle(1);

    // Back-to-back strobes, consumer always ready
    bus1.par_ready = 1'b1;
    sb_q.push_back(4'b1011);
    send_word(4'b1011);
    check_eq("t1_valid", bus1.par_valid, 1);
    check_eq("t1_data", bus1.par_data, 4'b1011);
    check_eq("t1_ovf", bus1.overflow, 0);
    check_eq("t1_busy", bus1.busy, 0);
    idle(1);
    check_eq("t1_pulse", bus1.par_valid, 0);

    // Gaps between strobes
    sb_q.push_back(4'b1011);
    bit_in(1'b1);
    check_eq("t2_busy_mid", bus1.busy, 1);
    idle(2);
    bit_in(1'b0); idle(1);
    bit_in(1'b1); idle(3);
    check_eq("t2_hold_valid", bus1.par_valid, 0);
    bit_in(1'b1);
    check_eq("t2_valid", bus1.par_valid, 1);
    check_eq("t2_data", bus1.par_data, 4'b1011);
    check_eq("t2_busy_done", bus1.busy, 0);
    idle(2);

    // Backpressure: second word dropped, first kept
    bus1.par_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_word(4'b1011);
    send_word(4'b0110);
    check_eq("t3_data_kept", bus1.par_data, 4'b1011);
    check_eq("t3_ovf_set", bus1.overflow, 1);
    check_eq("t3_valid_held", bus1.par_valid, 1);
    bus1.par_ready = 1'b1;
    idle(1);
    check_eq("t3_drained", bus1.par_valid, 0);
    check_eq("t3_ovf_sticky", bus1.overflow, 1);
    bus1.clr_ovf = 1'b1;
    idle(1);
    bus1.clr_ovf = 1'b0;
    check_eq("t3_ovf_clr", bus1.overflow, 0);

    // New word loads in the same cycle the held word drains
    bus1.par_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_word(4'b1011);
    sb_q.push_back(4'b0110);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    bus1.par_ready = 1'b1;
    bit_in(1'b0);
    check_eq("t4_valid", bus1.par_valid, 1);
    check_eq("t4_data", bus1.par_data, 4'b0110);
    check_eq("t4_ovf", bus1.overflow, 0);
    idle(2);
    check_eq("t4_empty", bus1.par_valid, 0);

    // Resynchronise with a bit in the same cycle
    bit_in(1'b1); bit_in(1'b1);
    bus1.frame_start = 1'b1; bus2.frame_start = 1'b1;
    bit_in(1'b0);
    bus1.frame_start = 1'b0; bus2.frame_start = 1'b0;
    check_eq("t5_fs_busy", bus1.busy, 1);
    check_eq("t5_fs_novalid", bus1.par_valid, 0);
    sb_q.push_back(4'b0101);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    check_eq("t5_data", bus1.par_data, 4'b0101);
    check_eq("t5_ovf", bus1.overflow, 0);
    idle(2);

    // Reset with a word held and a partial word in progress
    bus1.par_ready = 1'b0;
    send_word(4'b1001);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    check_eq("t5r_busy_pre", bus1.busy, 1);
    rst = 1'b1;
    #1;
    check_eq("t5r_valid", bus1.par_valid, 0);
    check_eq("t5r_data", bus1.par_data, 0);
    check_eq("t5r_busy", bus1.busy, 0);
    check_eq("t5r_ovf", bus1.overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.par_ready = 1'b1;
    sb_q.push_back(4'b0011);
    send_word(4'b0011);
    check_eq("t5r_word_valid", bus1.par_valid, 1);
    check_eq("t5r_word", bus1.par_data, 4'b0011);
    idle(2);

    // LSB-first instance
    sb_q.push_back(4'b1011);
    send_word(4'b1011);
    check_eq("t6_lsb_valid", bus2.par_valid, 1);
    check_eq("t6_lsb_data", bus2.par_data, 4'b1101);
    idle(1);
    sb_q.push_back(4'b0001);
    send_word(4'b0001);
    check_eq("t6_lsb_data2", bus2.par_data, 4'b1000);
    idle(3);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
